// File: rtl/sha256_pkg.sv
// Constants and padder state encoding shared between the SHA-256 padder and hash core.
package sha256_pkg;

    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          BLOCK_WORDS = 16;
    localparam int          BLOCK_BITS  = 512;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        EXTRA = 2'd2,
        EMIT  = 2'd3
    } pad_state_t;

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends the
// 0x80 marker and the 64-bit bit length, spilling into an extra block when needed.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [BLOCK_BITS-1:0] block_data,
    output logic                  block_valid,
    output logic                  block_last,
    input  logic                  block_ready,
    output logic [31:0]           msg_words,
    output logic                  err
);

    pad_state_t  state;
    logic [31:0] w [BLOCK_WORDS];
    logic [3:0]  p;          // next free slot in the block being filled
    logic [4:0]  q;          // first free slot after the final word (0..16)
    logic        extra;      // a length-only block still follows the one being emitted
    logic        msg_start;  // next accepted word begins a new message

    logic [31:0] cnt;
    logic        room;
    logic [31:0] len_hi, len_lo;

    assign cnt    = msg_start ? 32'd0 : msg_words;
    assign room   = cnt < 32'(MAX_WORDS);
    assign len_hi = {27'd0, msg_words[31:27]};
    assign len_lo = {msg_words[26:0], 5'd0};

    always_comb begin
        block_data = '0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            block_data[32*i +: 32] = w[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            p           <= '0;
            q           <= '0;
            extra       <= 1'b0;
            msg_start   <= 1'b1;
            in_ready    <= 1'b0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            msg_words   <= '0;
            err         <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++)
                w[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        msg_start <= 1'b0;
                        if (room) begin
                            w[p]      <= in_data;
                            msg_words <= cnt + 32'd1;
                            if (in_last) begin
                                q        <= {1'b0, p} + 5'd1;
                                state    <= PAD;
                                in_ready <= 1'b0;
                            end else if (p == 4'd15) begin
                                p           <= '0;
                                state       <= EMIT;
                                block_valid <= 1'b1;
                                block_last  <= 1'b0;
                                in_ready    <= 1'b0;
                            end else begin
                                p <= p + 4'd1;
                            end
                        end else begin
                            // Overflow words are dropped but may still end the message.
                            msg_words <= cnt;
                            err       <= 1'b1;
                            if (in_last) begin
                                q        <= {1'b0, p};
                                state    <= PAD;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < 14; i++)
                        if (5'(i) > q) w[i] <= '0;
                    if (q <= 5'd13) begin
                        w[q[3:0]] <= PAD_WORD;
                        w[14]     <= len_hi;
                        w[15]     <= len_lo;
                    end else if (q == 5'd14) begin
                        w[14] <= PAD_WORD;
                        w[15] <= '0;
                    end else if (q == 5'd15) begin
                        w[15] <= PAD_WORD;
                    end
                    extra       <= (q > 5'd13);
                    block_last  <= (q <= 5'd13);
                    block_valid <= 1'b1;
                    p           <= '0;
                    state       <= EMIT;
                end
                EXTRA: begin
                    w[0] <= (q == 5'd16) ? PAD_WORD : 32'd0;
                    for (int i = 1; i < 14; i++)
                        w[i] <= '0;
                    w[14]       <= len_hi;
                    w[15]       <= len_lo;
                    extra       <= 1'b0;
                    block_last  <= 1'b1;
                    block_valid <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        block_last  <= 1'b0;
                        if (extra) begin
                            state <= EXTRA;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            if (block_last) msg_start <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known-length messages, back-pressure, reset, overflow.
module tb_sha256_padder;

    typedef logic [31:0] words_t [16];

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         block_ready = 1'b0;
    logic         sel = 1'b0;

    logic         rdy0, bv0, bl0, err0, rdy1, bv1, bl1, err1;
    logic [511:0] bd0, bd1;
    logic [31:0]  mw0, mw1;

    sha256_padder dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .in_valid(in_valid && !sel), .in_last(in_last), .in_ready(rdy0),
        .block_data(bd0), .block_valid(bv0), .block_last(bl0),
        .block_ready(block_ready && !sel), .msg_words(mw0), .err(err0));

    sha256_padder #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .in_valid(in_valid && sel), .in_last(in_last), .in_ready(rdy1),
        .block_data(bd1), .block_valid(bv1), .block_last(bl1),
        .block_ready(block_ready && sel), .msg_words(mw1), .err(err1));

    wire         c_rdy = sel ? rdy1 : rdy0;
    wire         c_bv  = sel ? bv1 : bv0;
    wire         c_bl  = sel ? bl1 : bl0;
    wire [511:0] c_bd  = sel ? bd1 : bd0;

    always #5 clk = ~clk;

    logic [511:0] blk_q [$];
    logic         last_q [$];

    // Blocks transfer on the following rising edge; inputs only change just after edges.
    always @(negedge clk)
        if (c_bv && block_ready) begin
            blk_q.push_back(c_bd);
            last_q.push_back(c_bl);
        end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack(input words_t w);
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic words_t seq(input int n);
        words_t w;
        for (int i = 0; i < 16; i++) w[i] = (i < n) ? 32'(i + 1) : 32'd0;
        return w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        in_data = d; in_last = last; in_valid = 1'b1;
        while (!c_rdy && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("in_ready_timeout", 512'(c_rdy), 512'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_range(input int first, input int last_w, input int total);
        for (int i = first; i <= last_w; i++) send_word(32'(i), i == total);
    endtask

    task automatic wait_blocks(input int n);
        int t = 0;
        while (blk_q.size() < n && t < 300) begin @(posedge clk); #1; t++; end
        repeat (5) @(posedge clk);
        #1;
        chk("block_count", 512'(blk_q.size()), 512'(n));
    endtask

    words_t e;
    logic [511:0] snap;

    initial begin
        block_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 512'(rdy0), 512'd0);
        chk("rst_bv", 512'({bv0, bl0}), 512'd0);
        chk("rst_data", bd0, 512'd0);
        chk("rst_msg_err", 512'({mw0, err0}), 512'd0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 512'(rdy0), 512'd1);

        // 20 words
        blk_q.delete(); last_q.delete();
        send_range(1, 20, 20);
        wait_blocks(2);
        chk("m20_b1", blk_q[0], pack(seq(16)));
        chk("m20_l1", 512'(last_q[0]), 512'd0);
        e = seq(0);
        for (int i = 0; i < 4; i++) e[i] = 32'(17 + i);
        e[4] = 32'h8000_0000; e[15] = 32'h280;
        chk("m20_b2", blk_q[1], pack(e));
        chk("m20_l2", 512'(last_q[1]), 512'd1);
        chk("m20_words", 512'(mw0), 512'd20);

        // 13 words
        blk_q.delete(); last_q.delete();
        send_range(1, 13, 13);
        wait_blocks(1);
        e = seq(13); e[13] = 32'h8000_0000; e[15] = 32'h1A0;
        chk("m13_b1", blk_q[0], pack(e));
        chk("m13_l1", 512'(last_q[0]), 512'd1);
        chk("m13_words", 512'(mw0), 512'd13);

        // 14 words
        blk_q.delete(); last_q.delete();
        send_range(1, 14, 14);
        wait_blocks(2);
        e = seq(14); e[14] = 32'h8000_0000;
        chk("m14_b1", blk_q[0], pack(e));
        chk("m14_l1", 512'(last_q[0]), 512'd0);
        e = seq(0); e[15] = 32'h1C0;
        chk("m14_b2", blk_q[1], pack(e));
        chk("m14_l2", 512'(last_q[1]), 512'd1);

        // 16 words
        blk_q.delete(); last_q.delete();
        send_range(1, 16, 16);
        wait_blocks(2);
        chk("m16_b1", blk_q[0], pack(seq(16)));
        chk("m16_l1", 512'(last_q[0]), 512'd0);
        e = seq(0); e[0] = 32'h8000_0000; e[15] = 32'h200;
        chk("m16_b2", blk_q[1], pack(e));
        chk("m16_l2", 512'(last_q[1]), 512'd1);

        // 20 words with the first block held off for 10 cycles
        blk_q.delete(); last_q.delete();
        block_ready = 1'b0;
        send_range(1, 16, 20);
        chk("stall_bv", 512'(bv0), 512'd1);
        snap = bd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_data", bd0, snap);
            chk("stall_ctl", 512'({bv0, bl0, rdy0}), 512'b100);
        end
        block_ready = 1'b1;
        send_range(17, 20, 20);
        wait_blocks(2);
        chk("stall_b1", blk_q[0], pack(seq(16)));
        e = seq(0);
        for (int i = 0; i < 4; i++) e[i] = 32'(17 + i);
        e[4] = 32'h8000_0000; e[15] = 32'h280;
        chk("stall_b2", blk_q[1], pack(e));
        chk("stall_l2", 512'({last_q[0], last_q[1]}), 512'b01);

        // reset after 7 words discards the partial message
        blk_q.delete(); last_q.delete();
        send_range(1, 7, 100);
        reset_n = 1'b0;
        #3 reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_blocks", 512'(blk_q.size()), 512'd0);
        chk("rst_mid_words", 512'({mw0, bv0}), 512'd0);
        send_range(1, 13, 13);
        wait_blocks(1);
        e = seq(13); e[13] = 32'h8000_0000; e[15] = 32'h1A0;
        chk("rst_m13_b1", blk_q[0], pack(e));
        chk("rst_m13_l1", 512'(last_q[0]), 512'd1);

        // MAX_WORDS=4 instance fed 6 words
        blk_q.delete(); last_q.delete();
        sel = 1'b1;
        @(posedge clk); #1;
        send_range(1, 6, 6);
        wait_blocks(1);
        e = seq(4); e[4] = 32'h8000_0000; e[15] = 32'h80;
        chk("ovf_b1", blk_q[0], pack(e));
        chk("ovf_l1", 512'(last_q[0]), 512'd1);
        chk("ovf_err", 512'(err1), 512'd1);
        chk("ovf_words", 512'(mw1), 512'd4);
        chk("main_err_clear", 512'(err0), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024: maximum accepted message length in 32-bit words.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_data  input  32  message word.
REQ-005 SHALL have in_valid  input  1  in_data valid.
REQ-006 SHALL have in_last  input  1  in_data is the final message word.
REQ-007 SHALL have in_ready  output  1  padder accepts a word this cycle.
REQ-008 SHALL have block_data  output  512  padded block; word w[n] at bits [32n+31:32n].
REQ-009 SHALL have block_valid  output  1  block_data valid.
REQ-010 SHALL have block_last  output  1  block is the final block of the message.
REQ-011 SHALL have block_ready  input  1  downstream hash core consumes the block.
REQ-012 SHALL have msg_words  output  32  word count of the current/last message.
REQ-013 SHALL have err  output  1  sticky: message exceeded MAX_WORDS.

Function
REQ-014 SHALL transfer an input word on a rising edge where in_valid && in_ready, and a block where block_valid && block_ready.
REQ-015 SHALL use states FILL, PAD, EXTRA, EMIT. FILL: words are written to w[p], where p = 0..15 is the slot index.
REQ-016 in_ready SHALL be 1 only in FILL with block_valid low.
REQ-017 On an accepted non-last word at p=15: SHALL go to EMIT with block_valid=1 and block_last=0 on the next cycle; p returns to 0.
REQ-018 On an accepted last word at slot p: SHALL go to PAD (one cycle).
REQ-019 In PAD, with q = p+1 as the first free slot:
- q<=13: w[q]=0x80000000; w[q+1..13]=0; {w[14],w[15]} = 64-bit bit length (w14 high, w15 low); block_last=1.
- q=14 or 15: w[q]=0x80000000; remaining slots 0; block_last=0; next state EXTRA.
- q=16: emit the full data block with block_last=0; next state EXTRA, where EXTRA's block has w0=0x80000000.
REQ-020 EXTRA SHALL build a block with w[0..13]=0, except w0=0x80000000 when q=16, plus the length in w14/w15, and set block_last=1.
REQ-021 Bit length SHALL be msg_words*32, zero-extended to 64 bits.
REQ-022 block_data/block_valid/block_last SHALL hold stable while block_valid && !block_ready.
REQ-023 Latency: block_valid SHALL rise 1 cycle after the 16th-word accept, and 2 cycles after the last-word accept (PAD then EMIT).
REQ-024 After the block_last block is accepted: SHALL return to FILL with p=0; msg_words clears on the first word of the next message.
REQ-025 Words accepted beyond MAX_WORDS SHALL be discarded (not counted), set err, and still honour in_last for termination.
REQ-026 Each message SHALL contain at least one word; in_last on an accepted word is the only terminator.

Reset
REQ-027 reset_n low SHALL asynchronously force state=FILL, p=0, block_valid=0, block_last=0, in_ready=0 while in reset, block_data=0, msg_words=0, err=0.
REQ-028 Reset mid-message or mid-handshake SHALL discard the partial message; no block is emitted after release until new words arrive.
REQ-029 in_ready SHALL rise on the first clock edge after reset_n deasserts.

Structure
REQ-030 Package sha256_pkg SHALL hold: PAD_WORD=32'h80000000, BLOCK_WORDS=16, BLOCK_BITS=512, and the padder state enum, shared with the hash core.
REQ-031 SHALL be a single module with no sub-module; block storage is a 16x32 register array.

Verification
REQ-032 20 words 0x00000001..0x00000014 -> two blocks:
- block 1: w0..w15 = 1..16, block_last=0.
- block 2: w0..w3 = 17..20, w4=0x80000000, w5..w14=0, w15=0x00000280, block_last=1.
REQ-033 13 words -> one block: w13=0x80000000, w14=0, w15=0x000001A0, block_last=1.
REQ-034 14 words -> two blocks:
- block 1: w14=0x80000000, w15=0.
- block 2: w0..w14=0, w15=0x000001C0.
REQ-035 16 words -> two blocks:
- block 1: data only.
- block 2: w0=0x80000000, w15=0x00000200, block_last=1.
REQ-036 20-word message with block_ready held low 10 cycles -> block_data stable, in_ready=0 throughout; results identical to REQ-032.
REQ-037 Two further cases:
- MAX_WORDS=4 with 6 words -> err=1, msg_words=4, w15=0x80.
- reset_n pulsed after word 7 -> no block output; a fresh 13-word message then matches REQ-033.
